// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/game-over control, ball update strobe
// at a frame-divided rate that speeds up with paddle hits, goal detection and
// scoring. Optional build macro PONG_PAUSE_EN adds a pause_i input that
// toggles a pause flag in PLAY.
module pong_game_ctrl #(
    parameter int unsigned MaxScore       = 9,
    parameter int unsigned ServeFrames    = 60,
    parameter int unsigned XLeftGoal      = 8,
    parameter int unsigned XRightGoal     = 631,
    parameter int unsigned DivInit        = 4,
    parameter int unsigned HitsPerSpeedup = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       frame_end_i,
    input  logic       paddle_hit_i,
    input  logic [9:0] ball_x_i,
`ifdef PONG_PAUSE_EN
    input  logic       pause_i,
`endif
    output logic       update_ball_o,
    output logic       ball_center_o,
    output logic       serve_dir_o,
    output logic [3:0] score_l_o,
    output logic [3:0] score_r_o,
    output logic [2:0] game_state_o,
    output logic       winner_o
);

    localparam int unsigned ServeW = (ServeFrames > 1) ? $clog2(ServeFrames) : 1;
    localparam int unsigned HitW   = (HitsPerSpeedup > 1) ? $clog2(HitsPerSpeedup) : 1;

    localparam logic [ServeW-1:0] ServeLast = ServeW'(ServeFrames - 1);
    localparam logic [HitW-1:0]   HitLast   = HitW'(HitsPerSpeedup - 1);
    localparam logic [3:0]        DivInitV  = 4'(DivInit);
    localparam logic [3:0]        MaxScoreV = 4'(MaxScore);
    localparam logic [9:0]        XLeftV    = 10'(XLeftGoal);
    localparam logic [9:0]        XRightV   = 10'(XRightGoal);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StServe    = 3'd1,
        StPlay     = 3'd2,
        StPoint    = 3'd3,
        StGameOver = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          score_l_q, score_l_d;
    logic [3:0]          score_r_q, score_r_d;
    logic                update_ball_q, update_ball_d;
    logic                serve_dir_q, serve_dir_d;
    logic                winner_q, winner_d;
    logic                scorer_q, scorer_d;  // 1 = right player scored
    logic [3:0]          speed_div_q, speed_div_d;
    logic [3:0]          frame_cnt_q, frame_cnt_d;
    logic [ServeW-1:0]   serve_cnt_q, serve_cnt_d;
    logic [HitW-1:0]     hit_cnt_q, hit_cnt_d;
    logic                start_q;
    logic                start_rise;
    logic                play_active;

    assign start_rise = start_i & ~start_q;

`ifdef PONG_PAUSE_EN
    logic pause_q;
    logic paused_q, paused_d;
    logic pause_rise;

    assign pause_rise  = pause_i & ~pause_q;
    assign play_active = (state_q == StPlay) & ~paused_q;

    // Pause toggles only inside PLAY and is dropped whenever PLAY is left.
    always_comb begin
        paused_d = paused_q;
        if ((state_q == StPlay) && pause_rise) begin
            paused_d = ~paused_q;
        end
        if (state_d != StPlay) begin
            paused_d = 1'b0;
        end
    end

    // Pause edge detector and pause flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pause_q  <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            pause_q  <= pause_i;
            paused_q <= paused_d;
        end
    end
`else
    assign play_active = (state_q == StPlay);
`endif

    // Next-state logic for the game sequencer and its counters.
    always_comb begin
        state_d       = state_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        update_ball_d = 1'b0;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        scorer_d      = scorer_q;
        speed_div_d   = speed_div_q;
        frame_cnt_d   = frame_cnt_q;
        serve_cnt_d   = serve_cnt_q;
        hit_cnt_d     = hit_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    state_d   = StServe;
                end
            end

            StServe: begin
                if (frame_end_i) begin
                    if (serve_cnt_q == ServeLast) begin
                        serve_cnt_d = '0;
                        frame_cnt_d = 4'd0;
                        state_d     = StPlay;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end

            StPlay: begin
                if (play_active) begin
                    // Goal check uses the divider value from before any hit this cycle.
                    if (frame_end_i) begin
                        if (ball_x_i <= XLeftV) begin
                            scorer_d = 1'b1;
                            state_d  = StPoint;
                        end else if (ball_x_i >= XRightV) begin
                            scorer_d = 1'b0;
                            state_d  = StPoint;
                        end else if (frame_cnt_q == speed_div_q - 4'd1) begin
                            update_ball_d = 1'b1;
                            frame_cnt_d   = 4'd0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 4'd1;
                        end
                    end
                    if (paddle_hit_i) begin
                        if (hit_cnt_q == HitLast) begin
                            hit_cnt_d = '0;
                            if (speed_div_q > 4'd1) begin
                                speed_div_d = speed_div_q - 4'd1;
                            end
                            // Keep the frame counter inside the shortened period.
                            if (frame_cnt_d >= speed_div_d) begin
                                frame_cnt_d = speed_div_d - 4'd1;
                            end
                        end else begin
                            hit_cnt_d = hit_cnt_q + 1'b1;
                        end
                    end
                end
            end

            StPoint: begin
                if (scorer_q) begin
                    if (score_r_q < MaxScoreV) begin
                        score_r_d = score_r_q + 4'd1;
                    end
                    if (score_r_d == MaxScoreV) begin
                        winner_d = 1'b1;
                        state_d  = StGameOver;
                    end else begin
                        serve_dir_d = 1'b1;
                        speed_div_d = DivInitV;
                        hit_cnt_d   = '0;
                        state_d     = StServe;
                    end
                end else begin
                    if (score_l_q < MaxScoreV) begin
                        score_l_d = score_l_q + 4'd1;
                    end
                    if (score_l_d == MaxScoreV) begin
                        winner_d = 1'b0;
                        state_d  = StGameOver;
                    end else begin
                        serve_dir_d = 1'b0;
                        speed_div_d = DivInitV;
                        hit_cnt_d   = '0;
                        state_d     = StServe;
                    end
                end
            end

            StGameOver: begin
                if (start_rise) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    winner_d    = 1'b0;
                    speed_div_d = DivInitV;
                    hit_cnt_d   = '0;
                    state_d     = StServe;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            update_ball_q <= 1'b0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            scorer_q      <= 1'b0;
            speed_div_q   <= DivInitV;
            frame_cnt_q   <= 4'd0;
            serve_cnt_q   <= '0;
            hit_cnt_q     <= '0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            update_ball_q <= update_ball_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            scorer_q      <= scorer_d;
            speed_div_q   <= speed_div_d;
            frame_cnt_q   <= frame_cnt_d;
            serve_cnt_q   <= serve_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            start_q       <= start_i;
        end
    end

    assign update_ball_o = update_ball_q;
    assign ball_center_o = (state_q != StPlay);
    assign serve_dir_o   = serve_dir_q;
    assign score_l_o     = score_l_q;
    assign score_r_o     = score_r_q;
    assign game_state_o  = state_q;
    assign winner_o      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (default parameters).
// Build with PONG_PAUSE_EN defined to also exercise the pause input.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       frame_end;
    logic       paddle_hit;
    logic [9:0] ball_x;
    logic       update_ball;
    logic       ball_center;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] game_state;
    logic       winner;
`ifdef PONG_PAUSE_EN
    logic       pause;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;
    int c0;
    logic       u;
    logic [2:0] st;

    localparam logic [2:0] SIdle = 3'd0, SServe = 3'd1, SPlay = 3'd2, SPoint = 3'd3,
                           SOver = 3'd4;

    pong_game_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .frame_end_i  (frame_end),
        .paddle_hit_i (paddle_hit),
        .ball_x_i     (ball_x),
`ifdef PONG_PAUSE_EN
        .pause_i      (pause),
`endif
        .update_ball_o(update_ball),
        .ball_center_o(ball_center),
        .serve_dir_o  (serve_dir),
        .score_l_o    (score_l),
        .score_r_o    (score_r),
        .game_state_o (game_state),
        .winner_o     (winner)
    );

    always #5 clk = ~clk;

    // Counts clock cycles in which the update strobe is high.
    always @(posedge clk) if (update_ball === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame_end pulse; returns strobe and state seen one cycle later.
    task automatic frame(input logic [9:0] x, output logic uo, output logic [2:0] so);
        ball_x    = x;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        uo = update_ball;
        so = game_state;
        tick();
        tick();
    endtask

    task automatic hit(input int n);
        for (int i = 0; i < n; i++) begin
            paddle_hit = 1'b1;
            tick();
            paddle_hit = 1'b0;
            tick();
        end
    endtask

    task automatic serve_to_play();
        logic       lu;
        logic [2:0] ls;
        for (int i = 0; i < 60; i++) frame(10'd320, lu, ls);
    endtask

    // n mid-field frames; a strobe is expected on every period-th frame.
    task automatic run_frames(input int n, input int period, input string tag);
        logic       lu;
        logic [2:0] ls;
        for (int i = 1; i <= n; i++) begin
            frame(10'd320, lu, ls);
            check(tag, lu, (i % period == 0));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        frame_end  = 1'b0;
        paddle_hit = 1'b0;
        ball_x     = 10'd320;
`ifdef PONG_PAUSE_EN
        pause      = 1'b0;
`endif
        #12;
        check("rst_state", game_state, SIdle);
        check("rst_score_l", score_l, 0);
        check("rst_score_r", score_r, 0);
        check("rst_update", update_ball, 0);
        check("rst_center", ball_center, 1);
        check("rst_winner", winner, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Start edge -> SERVE, ball held centred
        start = 1'b1;
        tick();
        start = 1'b0;
        check("serve_entry", game_state, SServe);
        check("serve_center", ball_center, 1);

        c0 = upd_cnt;
        for (int i = 0; i < 59; i++) frame(10'd320, u, st);
        check("serve_59", game_state, SServe);
        frame(10'd320, u, st);
        check("play_entry", st, SPlay);
        check("play_center", ball_center, 0);
        check("serve_no_upd", upd_cnt - c0, 0);

        // Divider 4: strobes after frames 4, 8, 12
        c0 = upd_cnt;
        run_frames(12, 4, "div4");
        check("div4_count", upd_cnt - c0, 3);

        // Speed-ups: 4 -> 3 -> 2 -> 1, then saturate
        hit(4);
        run_frames(3, 3, "div3");
        hit(4);
        run_frames(2, 2, "div2");
        hit(4);
        c0 = upd_cnt;
        run_frames(5, 1, "div1");
        check("div1_count", upd_cnt - c0, 5);
        hit(4);
        run_frames(2, 1, "div1_sat");

        // Right player scores
        c0 = upd_cnt;
        frame(10'd5, u, st);
        check("goal_r_no_upd", u, 0);
        check("goal_r_point", st, SPoint);
        check("goal_r_score", score_r, 1);
        check("goal_r_dir", serve_dir, 1);
        check("goal_r_serve", game_state, SServe);
        check("goal_r_cnt", upd_cnt - c0, 0);
        serve_to_play();
        check("replay", game_state, SPlay);
        run_frames(4, 4, "div_reset");

        // Left player scores
        frame(10'd635, u, st);
        check("goal_l_score", score_l, 1);
        check("goal_l_dir", serve_dir, 0);
        check("goal_l_serve", game_state, SServe);

        for (int i = 0; i < 7; i++) begin
            serve_to_play();
            frame(10'd635, u, st);
        end
        check("score_l_8", score_l, 8);

        // Match point with start already held high
        serve_to_play();
        start = 1'b1;
        frame(10'd640, u, st);
        check("final_score", score_l, 9);
        check("gameover", game_state, SOver);
        check("winner_left", winner, 0);
        check("over_center", ball_center, 1);
        repeat (5) tick();
        check("no_restart_level", game_state, SOver);
        check("held_score", score_l, 9);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state", game_state, SServe);
        check("restart_score_l", score_l, 0);
        check("restart_score_r", score_r, 0);

        for (int i = 0; i < 3; i++) begin
            serve_to_play();
            frame(10'd5, u, st);
        end
        check("score_r_3", score_r, 3);
        serve_to_play();

`ifdef PONG_PAUSE_EN
        pause = 1'b1;
        tick();
        c0 = upd_cnt;
        for (int i = 0; i < 10; i++) frame(10'd320, u, st);
        check("paused_no_upd", upd_cnt - c0, 0);
        check("paused_state", game_state, SPlay);
        pause = 1'b0;
        tick();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        run_frames(4, 4, "resume");
`endif

        // Reset lands while a strobe is in flight
        for (int i = 0; i < 3; i++) frame(10'd320, u, st);
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        check("inflight_upd", update_ball, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", game_state, SIdle);
        check("arst_score_r", score_r, 0);
        check("arst_update", update_ball, 0);
        check("arst_center", ball_center, 1);
        check("arst_dir", serve_dir, 0);
        check("arst_winner", winner, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
